imem_resp: RTL

- Responder side of the instruction-memory interface: accepts the fetch stage's `imem_addr` and returns `imem_rdata` qualified by `imem_drdy`.
- Backing store is a byte-addressed array assembled little-endian into 32-bit words.
- Serves each new address after a fixed, parameterised access latency, standing in for a slow memory behind the core.
- Provides a byte-wide load port for bench or boot preload, and flags misaligned or out-of-range fetches.

---
 rtl/imem_resp.sv | 127 ++++++++++++
 1 files changed

// File: rtl/imem_resp.sv
// Instruction-memory responder: byte store, fixed-latency registered word read, fault flagging.
// Optional IMEM_STALL_INJECT_EN adds one extra wait cycle to every other access.
module imem_resp #(
  parameter int unsigned DEPTH_BYTES = 4096,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  output logic        imem_drdy,
  output logic [31:0] imem_rdata,
  output logic        imem_fault,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [7:0]  ld_data
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);
`ifdef IMEM_STALL_INJECT_EN
  localparam int unsigned CNT_W = 5;
`else
  localparam int unsigned CNT_W = 4;
`endif
  localparam logic [31:0] LAST_WORD = 32'(DEPTH_BYTES - 4);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  logic [7:0]       mem_q [DEPTH_BYTES];
  logic [1:0]       state_q, state_d;
  logic [31:0]      cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drdy_q, drdy_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             fault_q, fault_d;
`ifdef IMEM_STALL_INJECT_EN
  logic             toggle_q, toggle_d;
`endif

  logic          restart_c;
  logic          capture_c;
  logic          fault_c;
  logic [AW-1:0] word_base_c;
  logic [31:0]   word_c;
  logic          unused_ld_hi;

  assign unused_ld_hi = ^ld_addr[31:AW];

  // A load hitting the word in flight forces a re-read so post-write data is returned
  assign restart_c = ld_en && (state_q != ST_IDLE) &&
                     ((ld_addr[AW-1:0] >> 2) == (cur_addr_q[AW-1:0] >> 2));
  assign capture_c = (state_q == ST_IDLE) || (imem_addr != cur_addr_q) || restart_c;

  assign fault_c     = (cur_addr_q[1:0] != 2'b00) || (cur_addr_q > LAST_WORD);
  assign word_base_c = cur_addr_q[AW-1:0] & ~AW'(3);
  assign word_c      = {mem_q[word_base_c + AW'(3)], mem_q[word_base_c + AW'(2)],
                        mem_q[word_base_c + AW'(1)], mem_q[word_base_c]};

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    cnt_d      = cnt_q;
    drdy_d     = drdy_q;
    rdata_d    = rdata_q;
    fault_d    = fault_q;
`ifdef IMEM_STALL_INJECT_EN
    toggle_d   = toggle_q;
`endif
    if (capture_c) begin
      state_d    = ST_WAIT;
      cur_addr_d = imem_addr;
      drdy_d     = 1'b0;
      fault_d    = 1'b0;
`ifdef IMEM_STALL_INJECT_EN
      toggle_d   = ~toggle_q;
      cnt_d      = toggle_d ? CNT_W'(LATENCY + 1) : CNT_W'(LATENCY);
`else
      cnt_d      = CNT_W'(LATENCY);
`endif
    end else if (state_q == ST_WAIT) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d = ST_READY;
        drdy_d  = 1'b1;
        fault_d = fault_c;
        rdata_d = fault_c ? 32'h0 : word_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= 32'h0;
      cnt_q      <= '0;
      drdy_q     <= 1'b0;
      rdata_q    <= 32'h0;
      fault_q    <= 1'b0;
`ifdef IMEM_STALL_INJECT_EN
      toggle_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      cnt_q      <= cnt_d;
      drdy_q     <= drdy_d;
      rdata_q    <= rdata_d;
      fault_q    <= fault_d;
`ifdef IMEM_STALL_INJECT_EN
      toggle_q   <= toggle_d;
`endif
    end
  end

  // Store is never cleared by reset
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem_q[ld_addr[AW-1:0]] <= ld_data;
    end
  end

  assign imem_drdy  = drdy_q;
  assign imem_rdata = rdata_q;
  assign imem_fault = fault_q;

endmodule
